cpu_controller: RTL and testbench
=================================

CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low; deassertion synchronous to clk.
REQ-003 ena  input  1  run enable from clock/fetch sequencer; sampled every rising edge.
REQ-004 opcode  input  3  instruction opcode from instruction register out[7:5] (high byte).
REQ-005 zero  input  1  accumulator-zero flag.
REQ-006 rd  output  1  memory read strobe.
REQ-007 wr  output  1  memory write strobe.
REQ-008 load_ir  output  1  instruction register load enable (drives register load).
REQ-009 inc_pc  output  1  program counter increment.
REQ-010 load_pc  output  1  program counter parallel load (jump).
REQ-011 load_acc  output  1  accumulator load.
REQ-012 datactl_ena  output  1  accumulator-to-data-bus tri-state enable.
REQ-013 halt  output  1  CPU halted indicator.
REQ-014 state  output  3  current FSM state S0..S7, debug.

Function
REQ-015 Opcodes SHALL be HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111; ALU ops = ADD/AND/XOR.
REQ-016 An internal flag `active` SHALL load ena on every rising edge; while active=0, state SHALL be forced to S0 at each edge and all control outputs SHALL be 0.
REQ-017 While active=1 and not halted, state SHALL advance S0->S1->...->S7->S0 one step per rising edge, giving 8 cycles per instruction.
REQ-018 Dropping ena mid-instruction SHALL return state to S0 at the edge after the edge where ena=0 is sampled, with outputs 0 from that edge on; the aborted instruction is not resumed.
REQ-019 At the S2->S3 edge, opcode SHALL be captured into opc_q and zero into zero_q; S3..S7 decode SHALL use only opc_q/zero_q.
REQ-020 Outputs SHALL be combinational decode of state, opc_q, zero_q and active; any output not listed for a state SHALL be 0.
REQ-021 S0, S1: rd=1, load_ir=1, inc_pc=1, for every opcode (two-byte fetch).
REQ-022 S2: all outputs 0.
REQ-023 S3: opc_q=HLT -> halt=1; otherwise all 0.
REQ-024 S4: ALU/LDA -> rd=1; STO -> datactl_ena=1; JMP -> load_pc=1.
REQ-025 S5: ALU/LDA -> rd=1, load_acc=1; STO -> wr=1, datactl_ena=1; JMP -> load_pc=1; SKZ with zero_q=1 -> inc_pc=1.
REQ-026 S6: ALU/LDA -> rd=1; STO -> datactl_ena=1.
REQ-027 S7: SKZ with zero_q=1 -> inc_pc=1; otherwise all 0.
REQ-028 SKZ with zero_q=0 SHALL behave as a 2-increment no-op.
REQ-029 HLT SHALL set a sticky halted flag at the S3->S4 edge; once halted, state SHALL freeze at S4, halt=1, all other outputs 0, independent of ena; only rst_n clears it.
REQ-030 rd and wr SHALL never be 1 in the same cycle; load_pc and inc_pc SHALL never be 1 in the same cycle.

Reset
REQ-031 rst_n=0 SHALL immediately, without a clock, set state=S0, active=0, halted=0, opc_q=000, zero_q=0, forcing every output to 0 and state=0.
REQ-032 Reset asserted mid-instruction (any state, including halted) SHALL abort it; after release with ena=1, the first edge sets active and the S0 fetch outputs appear in that cycle.

Verification
REQ-033 Reset released, ena=1, opcode=101 (LDA): over 8 cycles, load_ir/rd/inc_pc=1 in S0,S1; rd=1 S4-S6; load_acc=1 only S5; inc_pc total 2.
REQ-034 opcode=110 (STO): datactl_ena=1 S4-S6, wr=1 only S5, rd=0 S2-S7, load_acc never 1.
REQ-035 opcode=001, zero=1: inc_pc pulses in S0,S1,S5,S7 (4 total); repeat with zero=0: 2 total.
REQ-036 opcode=111 (JMP): load_pc=1 in S4,S5 only; inc_pc never 1 S2-S7.
REQ-037 opcode=000 (HLT): halt=1 from S3, state frozen at 4; toggle ena and opcode for 20 cycles -> no change; assert rst_n=0 -> halt=0 and state=0 asynchronously.
REQ-038 ena deasserted in S5 of an LDA: state=0 and all outputs 0 after next edge; re-assert ena -> fresh fetch from S0, load_ir=1.

Source files
------------

// File: rtl/cpu_controller.sv
`default_nettype none
//============================================================================
// Module   : cpu_controller
// Brief    : Eight-phase instruction sequencer for a simple accumulator CPU.
//            Steps S0..S7 once per instruction while enabled, latches the
//            opcode and zero flag mid-instruction, decodes control strobes
//            combinationally and freezes in S4 after a HLT.
// Revision : 1.0 - initial release
//============================================================================
module cpu_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena_i,
    input  logic [2:0] opcode_i,
    input  logic       zero_i,
    output logic       rd_o,
    output logic       wr_o,
    output logic       load_ir_o,
    output logic       inc_pc_o,
    output logic       load_pc_o,
    output logic       load_acc_o,
    output logic       datactl_ena_o,
    output logic       halt_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
        S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
    } state_t;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    state_t     state_q, state_d;
    logic       active_q;
    logic       halted_q, halted_d;
    logic [2:0] opc_q, opc_d;
    logic       zero_q, zero_d;

    // Opcode classes used by the S4..S7 decode (latched opcode only).
    logic w_is_rdop;
    logic w_is_sto;
    logic w_is_jmp;
    logic w_skz_taken;

    assign w_is_rdop   = (opc_q == OP_ADD) || (opc_q == OP_AND) ||
                         (opc_q == OP_XOR) || (opc_q == OP_LDA);
    assign w_is_sto    = (opc_q == OP_STO);
    assign w_is_jmp    = (opc_q == OP_JMP);
    assign w_skz_taken = (opc_q == OP_SKZ) && zero_q;

    // State, enable, halt and instruction-latch registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S0;
            active_q <= 1'b0;
            halted_q <= 1'b0;
            opc_q    <= OP_HLT;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= ena_i;
            halted_q <= halted_d;
            opc_q    <= opc_d;
            zero_q   <= zero_d;
        end
    end

    // Next-state: halt freezes in S4, inactive parks in S0, else step forward.
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        opc_d    = opc_q;
        zero_d   = zero_q;
        if (halted_q) begin
            state_d = S4;
        end else if (!active_q) begin
            state_d = S0;
        end else begin
            if (state_q == S2) begin
                opc_d  = opcode_i;
                zero_d = zero_i;
            end
            if ((state_q == S3) && (opc_q == OP_HLT)) begin
                halted_d = 1'b1;
            end
            state_d = state_t'(state_q + 3'd1);
        end
    end

    // Control-strobe decode of the current phase and latched instruction.
    always_comb begin
        rd_o          = 1'b0;
        wr_o          = 1'b0;
        load_ir_o     = 1'b0;
        inc_pc_o      = 1'b0;
        load_pc_o     = 1'b0;
        load_acc_o    = 1'b0;
        datactl_ena_o = 1'b0;
        halt_o        = 1'b0;
        if (halted_q) begin
            halt_o = 1'b1;
        end else if (active_q) begin
            case (state_q)
                S0, S1: begin
                    rd_o      = 1'b1;
                    load_ir_o = 1'b1;
                    inc_pc_o  = 1'b1;
                end
                S3: begin
                    halt_o = (opc_q == OP_HLT);
                end
                S4: begin
                    rd_o          = w_is_rdop;
                    datactl_ena_o = w_is_sto;
                    load_pc_o     = w_is_jmp;
                end
                S5: begin
                    rd_o          = w_is_rdop;
                    load_acc_o    = w_is_rdop;
                    wr_o          = w_is_sto;
                    datactl_ena_o = w_is_sto;
                    load_pc_o     = w_is_jmp;
                    inc_pc_o      = w_skz_taken;
                end
                S6: begin
                    rd_o          = w_is_rdop;
                    datactl_ena_o = w_is_sto;
                end
                S7: begin
                    inc_pc_o = w_skz_taken;
                end
                default: begin
                end
            endcase
        end
    end

    assign state_o = state_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
//============================================================================
// Module   : tb_cpu_controller
// Brief    : Self-checking bench for cpu_controller with a cycle-level
//            reference model of the instruction sequencer.
// Revision : 1.0 - initial release
//============================================================================
module tb_cpu_controller;

    logic       clk;
    logic       rst_n;
    logic       ena_i;
    logic [2:0] opcode_i;
    logic       zero_i;
    logic       rd_o, wr_o, load_ir_o, inc_pc_o, load_pc_o, load_acc_o;
    logic       datactl_ena_o, halt_o;
    logic [2:0] state_o;

    cpu_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena_i         (ena_i),
        .opcode_i      (opcode_i),
        .zero_i        (zero_i),
        .rd_o          (rd_o),
        .wr_o          (wr_o),
        .load_ir_o     (load_ir_o),
        .inc_pc_o      (inc_pc_o),
        .load_pc_o     (load_pc_o),
        .load_acc_o    (load_acc_o),
        .datactl_ena_o (datactl_ena_o),
        .halt_o        (halt_o),
        .state_o       (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: phase within the instruction, enable, halt, latched fields.
    int       m_step;
    bit       m_active;
    bit       m_halted;
    bit [2:0] m_opc;
    bit       m_zero;

    // Per-instruction strobe tallies.
    int n_rd, n_wr, n_inc, n_ldpc, n_ldacc, n_dctl, n_ldir;

    // Expected strobes packed {rd,wr,load_ir,inc_pc,load_pc,load_acc,datactl,halt}.
    function automatic logic [7:0] expected_strobes();
        bit alu_or_lda, sto, jmp, skz_hit;
        logic [7:0] v;
        v = 8'h00;
        alu_or_lda = (m_opc inside {3'b010, 3'b011, 3'b100, 3'b101});
        sto        = (m_opc == 3'b110);
        jmp        = (m_opc == 3'b111);
        skz_hit    = (m_opc == 3'b001) && m_zero;
        if (m_halted) return 8'b0000_0001;
        if (!m_active) return 8'h00;
        case (m_step)
            0, 1: v = 8'b1011_0000;
            3:    v = (m_opc == 3'b000) ? 8'b0000_0001 : 8'h00;
            4:    v = {alu_or_lda, 3'b000, jmp, 1'b0, sto, 1'b0};
            5:    v = {alu_or_lda, sto, 1'b0, skz_hit, jmp, alu_or_lda, sto, 1'b0};
            6:    v = {alu_or_lda, 5'b00000, sto, 1'b0};
            7:    v = {3'b000, skz_hit, 4'b0000};
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_step = 0; m_active = 0; m_halted = 0; m_opc = 3'b000; m_zero = 0;
    endtask

    task automatic clear_counts();
        n_rd = 0; n_wr = 0; n_inc = 0; n_ldpc = 0; n_ldacc = 0; n_dctl = 0; n_ldir = 0;
    endtask

    // Compare all DUT outputs against the model right now.
    task automatic check_now(input string tag);
        logic [7:0] exp_v, got_v;
        logic [2:0] exp_s;
        exp_v = expected_strobes();
        exp_s = m_halted ? 3'd4 : 3'(m_step);
        got_v = {rd_o, wr_o, load_ir_o, inc_pc_o, load_pc_o, load_acc_o, datactl_ena_o, halt_o};
        tests_run++;
        if (got_v !== exp_v) begin
            tests_failed++;
            $display("FAIL %s strobes: got %b expected %b (step %0d opc %b)", tag, got_v, exp_v, m_step, m_opc);
        end
        tests_run++;
        if (state_o !== exp_s) begin
            tests_failed++;
            $display("FAIL %s state: got %0d expected %0d", tag, state_o, exp_s);
        end
        tests_run++;
        if ((rd_o && wr_o) || (inc_pc_o && load_pc_o)) begin
            tests_failed++;
            $display("FAIL %s exclusivity: rd=%b wr=%b inc_pc=%b load_pc=%b expected no overlap", tag, rd_o, wr_o, inc_pc_o, load_pc_o);
        end
        n_rd += rd_o; n_wr += wr_o; n_inc += inc_pc_o; n_ldpc += load_pc_o;
        n_ldacc += load_acc_o; n_dctl += datactl_ena_o; n_ldir += load_ir_o;
    endtask

    // One rising edge: update the model from the inputs seen at that edge, then check.
    task automatic tick(input string tag);
        @(posedge clk);
        if (m_halted) begin
            m_step = 4;
        end else if (!m_active) begin
            m_step = 0;
        end else begin
            if (m_step == 2) begin
                m_opc  = opcode_i;
                m_zero = zero_i;
            end
            if (m_step == 3 && m_opc == 3'b000) m_halted = 1;
            m_step = (m_step + 1) % 8;
        end
        m_active = ena_i;
        #1;
        check_now(tag);
    endtask

    // Asynchronous reset pulse, checked before any clock edge, released between edges.
    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_now(tag);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check_now(tag);
    endtask

    // Reset, enable, and land on S0 of a fresh instruction.
    task automatic start_fetch(input logic [2:0] opc, input logic z, input string tag);
        opcode_i = opc;
        zero_i   = z;
        ena_i    = 1'b1;
        do_reset(tag);
        clear_counts();
        tick(tag);
    endtask

    task automatic run_rest(input string tag);
        for (int i = 1; i < 8; i++) tick(tag);
    endtask

    task automatic expect_count(input string name, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        ena_i = 1'b0; opcode_i = 3'b101; zero_i = 1'b0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_hold");
        rst_n = 1'b1;
        tick("reset_idle");
        tick("reset_idle");
    endtask

    task automatic test_lda();
        start_fetch(3'b101, 1'b0, "lda");
        run_rest("lda");
        expect_count("lda_inc_pc_total", n_inc, 2);
        expect_count("lda_rd_total", n_rd, 5);
        expect_count("lda_load_acc_total", n_ldacc, 1);
        expect_count("lda_load_ir_total", n_ldir, 2);
    endtask

    task automatic test_sto();
        start_fetch(3'b110, 1'b1, "sto");
        run_rest("sto");
        expect_count("sto_datactl_total", n_dctl, 3);
        expect_count("sto_wr_total", n_wr, 1);
        expect_count("sto_rd_total", n_rd, 2);
        expect_count("sto_load_acc_total", n_ldacc, 0);
    endtask

    task automatic test_skz();
        start_fetch(3'b001, 1'b1, "skz1");
        run_rest("skz1");
        expect_count("skz_zero1_inc_pc", n_inc, 4);
        start_fetch(3'b001, 1'b0, "skz0");
        run_rest("skz0");
        expect_count("skz_zero0_inc_pc", n_inc, 2);
    endtask

    task automatic test_jmp();
        start_fetch(3'b111, 1'b0, "jmp");
        run_rest("jmp");
        expect_count("jmp_load_pc_total", n_ldpc, 2);
        expect_count("jmp_inc_pc_total", n_inc, 2);
    endtask

    task automatic test_hlt();
        start_fetch(3'b000, 1'b0, "hlt");
        for (int i = 1; i < 5; i++) tick("hlt");
        for (int i = 0; i < 20; i++) begin
            ena_i    = 1'($urandom);
            opcode_i = 3'($urandom);
            zero_i   = 1'($urandom);
            tick("hlt_frozen");
        end
        expect_count("hlt_state_frozen", int'(state_o), 4);
        expect_count("hlt_halt_held", int'(halt_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_count("hlt_async_clear_halt", int'(halt_o), 0);
        expect_count("hlt_async_clear_state", int'(state_o), 0);
        model_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_ena_drop();
        start_fetch(3'b101, 1'b0, "drop");
        for (int i = 1; i < 6; i++) tick("drop");
        ena_i = 1'b0;
        tick("drop_first_edge");
        expect_count("drop_outputs_zero",
                     int'({rd_o, wr_o, load_ir_o, inc_pc_o, load_pc_o, load_acc_o, datactl_ena_o, halt_o}), 0);
        tick("drop_second_edge");
        expect_count("drop_state_s0", int'(state_o), 0);
        ena_i = 1'b1;
        tick("drop_refetch");
        expect_count("drop_refetch_load_ir", int'(load_ir_o), 1);
        expect_count("drop_refetch_state", int'(state_o), 0);
    endtask

    task automatic test_random();
        int halted_cycles;
        halted_cycles = 0;
        ena_i = 1'b1;
        do_reset("rand");
        for (int i = 0; i < 1500; i++) begin
            ena_i    = ($urandom_range(0, 15) != 0);
            opcode_i = 3'($urandom);
            zero_i   = 1'($urandom);
            if (m_halted) halted_cycles++;
            if (halted_cycles > 6 || $urandom_range(0, 199) == 0) begin
                halted_cycles = 0;
                ena_i = 1'b1;
                do_reset("rand_reset");
            end
            tick("rand");
        end
    endtask

    initial begin
        rst_n = 1'b0; ena_i = 1'b0; opcode_i = 3'b000; zero_i = 1'b0;
        model_reset();
        clear_counts();
        test_reset();
        test_lda();
        test_sto();
        test_skz();
        test_jmp();
        test_hlt();
        test_ena_drop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
